key_event_decoder: RTL and testbench

// - Input side of the board UI. The LED drivers push state out to the LEDs; this block takes raw

---
 rtl/key_event_pkg.sv | 33 +++
 rtl/key_event_ch.sv | 124 ++++++++++++
 rtl/key_event_decoder.sv | 50 +++++
 tb/tb_key_event_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types and default cycle constants for the pushbutton event decoder.
package key_event_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } key_state_e;

   // One channel's registered outputs.
   typedef struct packed {
      logic level;
      logic press;
      logic rls;
      logic click;
      logic lng;
   } key_evt_t;

   // Defaults for a 125 MHz system clock.
   localparam int KEY_N_KEYS            = 3;
   localparam int KEY_DEBOUNCE_CYCLES   = 2_500_000;     // 20 ms
   localparam int KEY_LONG_PRESS_CYCLES = 125_000_000;   // 1 s
   localparam int KEY_REPEAT_CYCLES     = 25_000_000;    // 200 ms
   localparam int KEY_CNT_W             = 27;

   // True when a CNT_W-bit counter can hold every cycle constant.
   function automatic bit cnt_fits(input int w, input int a, input int b, input int c);
      longint lim;
      lim = longint'(1) << w;
      return (longint'(a) <= lim) && (longint'(b) <= lim) && (longint'(c) <= lim);
   endfunction

endpackage

// File: rtl/key_event_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, click/long-press FSM.
// Macro KEY_AUTOREPEAT_EN: long_pulse repeats every REPEAT_CYCLES while held in LONG.
module key_event_ch
   import key_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = KEY_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = KEY_LONG_PRESS_CYCLES,
`ifdef KEY_AUTOREPEAT_EN
   parameter int REPEAT_CYCLES     = KEY_REPEAT_CYCLES,
`endif
   parameter int CNT_W             = KEY_CNT_W
) (
   input  logic     sys_clk,
   input  logic     sys_rstn,
   input  logic     raw,
   output key_evt_t evt
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

   logic [1:0]       sync_q;
   logic             s;
   logic             lvl_q;
   logic [CNT_W-1:0] db_cnt_q;
   logic             rise_q, fall_q;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   key_evt_t         evt_d;

   assign s = sync_q[1];

   // Bring the asynchronous pin into sys_clk.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) sync_q <= '0;
      else           sync_q <= {sync_q[0], raw};
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
   // rise_q/fall_q are one-cycle strobes of an accepted change.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         lvl_q    <= 1'b0;
         db_cnt_q <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (s == lvl_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DB_LAST) begin
            lvl_q    <= s;
            db_cnt_q <= '0;
            rise_q   <= s;
            fall_q   <= ~s;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
      end
   end

   // State, hold counter and all outputs are registered together.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q <= IDLE;
         hold_q  <= '0;
         evt     <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         evt     <= evt_d;
      end
   end

   // Press/release classification; a release always beats a coincident long threshold.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      evt_d       = '0;
      evt_d.level = lvl_q;
      case (state_q)
         IDLE: begin
            if (rise_q) begin
               state_d     = PRESSED;
               hold_d      = '0;
               evt_d.press = 1'b1;
            end
         end
         PRESSED: begin
            if (fall_q) begin
               state_d     = IDLE;
               evt_d.rls   = 1'b1;
               evt_d.click = 1'b1;
            end else if (hold_q == LONG_LAST) begin
               state_d   = LONG;
               hold_d    = '0;
               evt_d.lng = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         LONG: begin
            if (fall_q) begin
               state_d   = IDLE;
               evt_d.rls = 1'b1;
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (hold_q == REP_LAST) begin
               hold_d    = '0;
               evt_d.lng = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/key_event_decoder.sv
// Pushbutton front end: N_KEYS independent debounce/classify channels.
// Macro KEY_AUTOREPEAT_EN enables long-press auto-repeat in every channel.
module key_event_decoder
   import key_event_pkg::*;
#(
   parameter int N_KEYS            = KEY_N_KEYS,
   parameter int DEBOUNCE_CYCLES   = KEY_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = KEY_LONG_PRESS_CYCLES,
   parameter int REPEAT_CYCLES     = KEY_REPEAT_CYCLES,
   parameter int CNT_W             = KEY_CNT_W
) (
   input  logic              sys_clk,
   input  logic              sys_rstn,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] click_pulse,
   output logic [N_KEYS-1:0] long_pulse
);

   // Marker block: elaborates only when CNT_W cannot hold a cycle constant.
   if (!cnt_fits(CNT_W, DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES)) begin : g_cnt_w_too_small
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_evt_t evt;

      key_event_ch #(
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
`ifdef KEY_AUTOREPEAT_EN
         .REPEAT_CYCLES     (REPEAT_CYCLES),
`endif
         .CNT_W             (CNT_W)
      ) u_ch (
         .sys_clk  (sys_clk),
         .sys_rstn (sys_rstn),
         .raw      (key_raw[i]),
         .evt      (evt)
      );

      assign key_level[i]     = evt.level;
      assign press_pulse[i]   = evt.press;
      assign release_pulse[i] = evt.rls;
      assign click_pulse[i]   = evt.click;
      assign long_pulse[i]    = evt.lng;
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed vector table, multi-cycle corner sequences,
// and random key activity checked every cycle against a window-based reference model.
module tb_key_event_decoder;

   localparam int NK = 3;
   localparam int D  = 8;
   localparam int L  = 32;
   localparam int R  = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [NK-1:0] key_raw = '0;
   logic [NK-1:0] key_level, press_pulse, release_pulse, click_pulse, long_pulse;

   key_event_decoder #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(27)
   ) dut (
      .sys_clk(clk), .sys_rstn(rstn), .key_raw(key_raw),
      .key_level(key_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .click_pulse(click_pulse), .long_pulse(long_pulse)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: raw sample history since reset plus accepted/visible levels.
   logic [NK-1:0] hist[$];
   bit            int_lvl[NK];
   bit            out_lvl[NK];
   int            pcyc[NK];

   // Per-run recording of DUT events (cycle numbers relative to clear_rec).
   int cyc;
   int act_press[NK], act_rel[NK], act_clicks[NK], act_longs[NK], act_any[NK];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic samp(input int j, input int k);
      if (j < 0) return 1'b0;
      return hist[j][k];
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < NK; k++) begin
         int_lvl[k] = 0; out_lvl[k] = 0; pcyc[k] = 0;
      end
   endtask

   // Edge t: visible level is the level accepted at t-1; a key is accepted once
   // the D raw samples taken at edges t-D-1..t-2 all differ from the accepted level.
   task automatic model_step(input logic [NK-1:0] raw_now, output logic [14:0] exp);
      int t, d;
      bit all_diff;
      logic [NK-1:0] e_lvl, e_prs, e_rls, e_clk, e_lng;
      t = hist.size();
      hist.push_back(raw_now);
      e_lvl = '0; e_prs = '0; e_rls = '0; e_clk = '0; e_lng = '0;
      for (int k = 0; k < NK; k++) begin
         e_lvl[k] = int_lvl[k];
         if (e_lvl[k] && !out_lvl[k]) begin
            e_prs[k] = 1'b1;
            pcyc[k]  = t;
         end
         if (!e_lvl[k] && out_lvl[k]) begin
            e_rls[k] = 1'b1;
            e_clk[k] = (t - pcyc[k] <= L);
         end
         if (e_lvl[k] && out_lvl[k]) begin
            d = t - pcyc[k];
            if (d == L) e_lng[k] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            if (d > L && (d - L) % R == 0) e_lng[k] = 1'b1;
`endif
         end
         out_lvl[k] = e_lvl[k];
         all_diff = 1;
         for (int j = t - D - 1; j <= t - 2; j++)
            if (samp(j, k) == int_lvl[k]) all_diff = 0;
         if (all_diff) int_lvl[k] = !int_lvl[k];
      end
      exp = {e_lvl, e_prs, e_rls, e_clk, e_lng};
   endtask

   task automatic clear_rec();
      cyc = 0;
      for (int k = 0; k < NK; k++) begin
         act_press[k] = -1; act_rel[k] = -1; act_clicks[k] = 0; act_longs[k] = 0; act_any[k] = 0;
      end
   endtask

   // One clock: sample raw at the edge, check all outputs 1 time unit later.
   task automatic tick();
      logic [NK-1:0] raw_now;
      logic [14:0]   exp, act;
      @(posedge clk);
      raw_now = key_raw;
      #1;
      if (!rstn) begin
         model_reset();
         exp = '0;
      end else begin
         model_step(raw_now, exp);
      end
      act = {key_level, press_pulse, release_pulse, click_pulse, long_pulse};
      check("cycle_outputs", 32'(act), 32'(exp));
      for (int k = 0; k < NK; k++) begin
         if (press_pulse[k] && act_press[k] < 0) act_press[k] = cyc;
         if (release_pulse[k]) act_rel[k] = cyc;
         if (click_pulse[k]) act_clicks[k]++;
         if (long_pulse[k]) act_longs[k]++;
         if (key_level[k] | press_pulse[k] | release_pulse[k] | click_pulse[k] | long_pulse[k])
            act_any[k] = 1;
      end
      cyc++;
   endtask

   typedef struct {
      int key; int rise; int hold;
      int exp_press; int exp_rel; int exp_clicks; int exp_longs;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int rem[NK];
      int n;

`ifdef KEY_AUTOREPEAT_EN
      n = 1;
`else
      n = 0;
`endif
      //          key rise hold press rel  clicks longs
      vecs[0] = '{1,  10,  20,  20,   40,  1,     0};
      vecs[1] = '{2,  0,   100, 10,   110, 0,     (n != 0) ? 9 : 1};
      vecs[2] = '{0,  0,   32,  10,   42,  1,     0};              // release on threshold
      vecs[3] = '{0,  0,   33,  10,   43,  0,     1};
      vecs[4] = '{0,  0,   8,   10,   18,  1,     0};              // shortest accepted
      vecs[5] = '{1,  3,   7,   -1,   -1,  0,     0};              // one cycle too short
      model_reset();
      clear_rec();

      // Reset held, then 100 idle cycles.
      repeat (3) tick();
      rstn = 1'b1;
      clear_rec();
      repeat (100) tick();
      check("idle_activity", 32'(act_any[0] + act_any[1] + act_any[2]), 32'd0);

      // Directed table.
      foreach (vecs[v]) begin
         clear_rec();
         for (int c = 0; c < vecs[v].rise + vecs[v].hold + D + 6; c++) begin
            key_raw = '0;
            key_raw[vecs[v].key] = (c >= vecs[v].rise) && (c < vecs[v].rise + vecs[v].hold);
            tick();
         end
         check($sformatf("vec%0d_press", v),  32'(act_press[vecs[v].key]),  32'(vecs[v].exp_press));
         check($sformatf("vec%0d_release", v), 32'(act_rel[vecs[v].key]),   32'(vecs[v].exp_rel));
         check($sformatf("vec%0d_clicks", v), 32'(act_clicks[vecs[v].key]), 32'(vecs[v].exp_clicks));
         check($sformatf("vec%0d_longs", v),  32'(act_longs[vecs[v].key]),  32'(vecs[v].exp_longs));
      end

      // Bounce: key 0 toggles every 3 cycles for 40 cycles, then low.
      clear_rec();
      for (int c = 0; c < 60; c++) begin
         key_raw = '0;
         key_raw[0] = (c < 40) && ((c / 3) % 2 == 0);
         tick();
      end
      check("bounce_activity", 32'(act_any[0]), 32'd0);

      // All keys together, then asynchronous reset mid-press.
      clear_rec();
      key_raw = '1;
      for (int c = 0; c <= 25; c++) tick();
      for (int k = 0; k < NK; k++) check($sformatf("simul_press%0d", k), 32'(act_press[k]), 32'd10);
      #2 rstn = 1'b0;
      #1;
      check("async_reset", 32'({key_level, press_pulse, release_pulse, click_pulse, long_pulse}), 32'd0);
      repeat (3) tick();
      rstn = 1'b1;
      clear_rec();
      repeat (20) tick();
      for (int k = 0; k < NK; k++) check($sformatf("repress%0d", k), 32'(act_press[k]), 32'd10);
      key_raw = '0;
      repeat (20) tick();

      // Random key activity, runs from bounce-length up to well past the long time.
      for (int k = 0; k < NK; k++) rem[k] = 1;
      repeat (3000) begin
         for (int k = 0; k < NK; k++) begin
            rem[k]--;
            if (rem[k] <= 0) begin
               key_raw[k] = ~key_raw[k];
               rem[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(40, 120))
                                                    : int'($urandom_range(1, 30));
            end
         end
         tick();
      end
      key_raw = '0;
      repeat (40) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
